// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit.
//   DEFAULT_GROUP_W : default bits per lookahead group (one pipeline stage each)
//   MODE_ADD/SUB    : encoding of the 'sub' input
//   num_groups()    : number of groups, which is also the pipeline depth
package pipelined_cla_pkg;

  localparam int DEFAULT_GROUP_W = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int num_groups(input int width, input int group_w);
    // Guard the divide so a bad GROUP_W reaches the elaboration check cleanly.
    return (group_w > 0) ? (width / group_w) : 1;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// Combinational GROUP_W-bit carry-lookahead group.
//   a_i, b_i  : group operand bits
//   cin_i     : carry into the group
//   sum_o     : group sum bits
//   cout_o    : carry out of the group MSB
//   p_o, g_o  : group propagate / generate
//   c_msb_o   : carry into the group MSB (used for signed overflow)
module cla_group #(
  parameter int GROUP_W = 4
) (
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               cin_i,
  output logic [GROUP_W-1:0] sum_o,
  output logic               cout_o,
  output logic               p_o,
  output logic               g_o,
  output logic               c_msb_o
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W:0]   carry;
  logic               grp_gen;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Each carry is a flat sum of products over all lower bits rather than a ripple chain.
  always_comb begin
    logic prop;
    prop     = 1'b0;
    carry    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < GROUP_W; i++) begin
      carry[i+1] = g[i];
      prop       = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry[i+1] = carry[i+1] | (prop & g[j]);
        prop       = prop & p[j];
      end
      carry[i+1] = carry[i+1] | (prop & cin_i);
    end
  end

  always_comb begin
    grp_gen = 1'b0;
    for (int i = 0; i < GROUP_W; i++) begin
      grp_gen = g[i] | (p[i] & grp_gen);
    end
  end

  assign sum_o   = p ^ carry[GROUP_W-1:0];
  assign cout_o  = carry[GROUP_W];
  assign c_msb_o = carry[GROUP_W-1];
  assign p_o     = &p;
  assign g_o     = grp_gen;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: one GROUP_W-bit lookahead group per stage, group carry
// registered between stages, valid/ready with full backpressure on both sides.
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational from the output side)
//   a, b, cin, sub       : operands; sub=1 computes A + ~B + 1 and ignores cin
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry out of MSB (sub: 1 = no borrow), signed overflow
// Optional macro PIPELINED_CLA_ADDER_SAT_EN: signed saturation of sum in the last stage.
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int GROUP_W = DEFAULT_GROUP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NumGroups = num_groups(WIDTH, GROUP_W);

  if (GROUP_W < 1) begin : g_bad_group_w
    $error("pipelined_cla_adder: GROUP_W must be at least 1");
  end else if ((WIDTH % GROUP_W) != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP_W");
  end

`ifdef PIPELINED_CLA_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_d, ovf_q;

  // Whole pipeline advances together; an empty output slot always lets it move.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  always_comb begin
    b_eff = b;
    c0    = cin;
    unique case (sub)
      MODE_ADD: begin
        b_eff = b;
        c0    = cin;
      end
      MODE_SUB: begin
        b_eff = ~b;
        c0    = 1'b1;
      end
    endcase
  end

  for (genvar g = 0; g < NumGroups; g++) begin : g_stage
    localparam int SumW = GROUP_W * (g + 1);

    logic [GROUP_W-1:0] grp_a, grp_b, grp_sum;
    logic               grp_cin, grp_cout, grp_cmsb, grp_p, grp_g;
    logic               valid_d, valid_q;
    logic               c_d, c_q;
    logic [SumW-1:0]    psum_raw, psum_d, psum_q;
    logic               unused_grp;

    if (g == 0) begin : g_src
      assign grp_a    = a[GROUP_W-1:0];
      assign grp_b    = b_eff[GROUP_W-1:0];
      assign grp_cin  = c0;
      assign valid_d  = in_valid;
      assign psum_raw = grp_sum;
    end else begin : g_src
      assign grp_a    = g_stage[g-1].g_op.rem_a_q[GROUP_W-1:0];
      assign grp_b    = g_stage[g-1].g_op.rem_b_q[GROUP_W-1:0];
      assign grp_cin  = g_stage[g-1].c_q;
      assign valid_d  = g_stage[g-1].valid_q;
      assign psum_raw = {grp_sum, g_stage[g-1].psum_q};
    end

    cla_group #(
      .GROUP_W(GROUP_W)
    ) u_group (
      .a_i    (grp_a),
      .b_i    (grp_b),
      .cin_i  (grp_cin),
      .sum_o  (grp_sum),
      .cout_o (grp_cout),
      .p_o    (grp_p),
      .g_o    (grp_g),
      .c_msb_o(grp_cmsb)
    );

    // Group P/G are exposed for wider lookahead trees; this pipeline only needs the carry.
    assign unused_grp = ^{grp_p, grp_g, grp_cmsb};
    assign c_d        = grp_cout;

    if (g == NumGroups - 1) begin : g_fin
`ifdef PIPELINED_CLA_ADDER_SAT_EN
      // On overflow both transformed MSBs agree, so either one gives the true sign.
      always_comb begin
        psum_d = psum_raw;
        if (ovf_d) begin
          psum_d = grp_a[GROUP_W-1] ? SatNeg : SatPos;
        end
      end
`else
      assign psum_d = psum_raw;
`endif
    end else begin : g_fin
      assign psum_d = psum_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        psum_q  <= '0;
      end else if (en) begin
        valid_q <= valid_d;
        c_q     <= c_d;
        psum_q  <= psum_d;
      end
    end

    // Operand bits not yet consumed ride along, shrinking by one group per stage.
    if (g < NumGroups - 1) begin : g_op
      localparam int RemW = WIDTH - GROUP_W * (g + 1);

      logic [RemW-1:0] rem_a_d, rem_a_q, rem_b_d, rem_b_q;

      if (g == 0) begin : g_shift
        assign rem_a_d = a[WIDTH-1:GROUP_W];
        assign rem_b_d = b_eff[WIDTH-1:GROUP_W];
      end else begin : g_shift
        assign rem_a_d = g_stage[g-1].g_op.rem_a_q[RemW+GROUP_W-1:GROUP_W];
        assign rem_b_d = g_stage[g-1].g_op.rem_b_q[RemW+GROUP_W-1:GROUP_W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (en) begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
        end
      end
    end
  end

  assign ovf_d = g_stage[NumGroups-1].grp_cout ^ g_stage[NumGroups-1].grp_cmsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[NumGroups-1].valid_q;
  assign sum       = g_stage[NumGroups-1].psum_q;
  assign cout      = g_stage[NumGroups-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined add/subtract unit built from GROUP_W-bit carry-lookahead groups.
- Each group computes in its own pipeline stage; the group carry is registered between stages.
- Sits on arithmetic datapaths that need WIDTH > 8 at full clock rate.
- Valid/ready handshake on both sides, with full backpressure.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of GROUP_W.
- GROUP_W, 4, bits per lookahead group (one pipeline stage per group).
- NUM_GROUPS, WIDTH/GROUP_W, derived, not overridable; equals pipeline depth.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (ignored when sub=1)
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (async, active-high) clears all stage valid bits, data registers, sum, cout, ovf and out_valid to 0. Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Advance enable: en = out_ready | ~out_valid. in_ready = en, so it is combinational from out_ready and out_valid.
- Acceptance: a beat is accepted when in_valid & in_ready.
- Stage 0 on acceptance:
  - applies the sub transform (b_eff = ~b, c0 = 1; else b_eff = b, c0 = cin);
  - computes group 0;
  - registers: partial sum bits [GROUP_W-1:0], group carry out, unconsumed upper a/b_eff bits, valid.
- Stage k (1..NUM_GROUPS-1), when en: computes group k from the registered operand bits and registered carry, then shifts them forward.
- Registers hold when en=0. No bubble collapsing: a bubble stays a bubble.
- Latency: NUM_GROUPS cycles from acceptance edge to out_valid, with out_ready held high.
- Throughput: 1 beat per cycle.
- Order is strictly preserved (FIFO).
- Outputs:
  - cout = carry out of the last group.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
  - In sub mode, the flags reflect A + ~B + 1.
- Simultaneous events: with out_valid=1 and out_ready=1, the result retires and a new beat can enter the same cycle.
- Stall: with out_valid=1 and out_ready=0, sum/cout/ovf are held stable and in_ready=0.
- Wrap-around: results are modulo 2^WIDTH.
- Elaboration error if WIDTH % GROUP_W != 0 or GROUP_W < 1.

Optional Feature:
- Macro: PIPELINED_CLA_ADDER_SAT_EN.
- Defined: signed saturation in the last stage.
  - If ovf=1, sum = 0x7F..F when the true result is positive (operand MSBs both 0 after transform), else 0x80..0.
  - ovf still reports 1; cout is unchanged.
  - Latency is unchanged.
- Undefined: sum wraps; no saturation logic is instantiated.

Decomposition:
- Package pipelined_cla_pkg:
  - default GROUP_W constant;
  - mode encoding localparams MODE_ADD=0, MODE_SUB=1;
  - function for the number of groups.
- Sub-module cla_group:
  - combinational GROUP_W-bit lookahead group;
  - inputs a, b, cin; outputs sum, cout, group P/G, carry into MSB (for ovf).
  - Instantiated once per stage via generate.

Test Plan (WIDTH=8, GROUP_W=4, latency 2 unless noted):
- a=FF, b=01, cin=0, sub=0 -> 2 cycles later sum=00, cout=1, ovf=0.
- a=7F, b=01, sub=0 -> sum=80, ovf=1, cout=0. With SAT_EN -> sum=7F, ovf=1.
- a=05, b=07, sub=1 -> sum=FE, cout=0, ovf=0. Then a=80, b=01, sub=1 -> sum=7F, ovf=1 (SAT_EN: 80).
- Stream 8 back-to-back beats (i + 2i, i=0..7):
  - with out_ready=1 -> results in order, one per cycle;
  - with out_ready low for 3 cycles mid-stream -> in_ready=0, outputs held, no loss or duplication.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 immediately; no stale result after release; next beat has latency 2.
- WIDTH=32, GROUP_W=4: a=FFFFFFFF, b=00000001 -> sum=0, cout=1 after 8 cycles. Random 1000 beats vs golden model.
